hxd_ifq: RTL and testbench

Parametrised instruction fetch queue for the hxd32 core family. Sits between the instruction RAM port and the decode stage: it owns the fetch PC, issues one sequential fetch per cycle into a synchronous 1-cycle-latency IRAM, and buffers returned words with their PCs in a DEPTH-entry FIFO. Decode back-pressures it with `stall_i`. Taken branches and jumps flush it via `redirect_i`. It optionally raises a sticky fault on an all-zero instruction word.

---
 rtl/hxd_ifq.sv | 130 +++++++++++++
 tb/tb_hxd_ifq.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hxd_ifq.sv
// hxd_ifq: instruction fetch queue that owns the fetch PC, issues sequential IRAM reads and buffers {pc, word} pairs.
// Optional zero-word fault detection (sticky fault_o, fetch freeze) is built when HXD_IFQ_ZERO_FAULT_EN is defined.
module hxd_ifq #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  output logic                   iram_rd_en_o,
  output logic [XLEN-1:0]        iram_rd_addr_o,
  input  logic [XLEN-1:0]        iram_rd_data_i,
  input  logic                   redirect_i,
  input  logic [XLEN-1:0]        redirect_pc_i,
  input  logic                   stall_i,
  output logic                   inst_valid_o,
  output logic [XLEN-1:0]        inst_data_o,
  output logic [XLEN-1:0]        inst_pc_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   fault_o
);

  localparam int unsigned     AW         = $clog2(DEPTH);
  localparam logic [AW+1:0]   DEPTH_W    = (AW+2)'(DEPTH);
  localparam logic [AW:0]     PTR_ONE    = (AW+1)'(1);
  localparam logic [XLEN-1:0] NOP        = XLEN'(32'h13);
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] word;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          head;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic            inflight_q, inflight_d;
  logic [AW:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]     level;
  logic [AW+1:0]   used, limit;
  logic            head_present, head_ok, fault_act;
  logic            push, pop, issue;

  // Pointers carry one extra wrap bit, so their difference is the occupancy.
  assign level        = wptr_q - rptr_q;
  assign head_present = (level != '0);
  assign head         = mem_q[rptr_q[AW-1:0]];

`ifdef HXD_IFQ_ZERO_FAULT_EN
  logic fault_q, fault_d;
  logic head_zero;

  // A zero word at the head is never offered to decode; it latches the fault instead.
  assign head_zero = head_present && (head.word == '0);
  assign fault_d   = fault_q | head_zero;
  assign fault_act = fault_q;
  assign head_ok   = head_present && !head_zero && !fault_q;
  assign fault_o   = fault_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) fault_q <= 1'b0;
    else       fault_q <= fault_d;
  end
`else
  assign fault_act = 1'b0;
  assign head_ok   = head_present;
  assign fault_o   = 1'b0;
`endif

  assign pop  = head_ok & ~stall_i;
  assign push = inflight_q & ~redirect_i & ~fault_act;

  // Credit check: buffered + in-flight entries after this cycle's pop must leave room.
  assign used  = {1'b0, level} + {{(AW+1){1'b0}}, inflight_q};
  assign limit = DEPTH_W + {{(AW+1){1'b0}}, pop};
  assign issue = ~rst_i & ~fault_act & ~redirect_i & (used < limit);

  // NOTE: every signal gets its default first, so no path leaves a latch behind.
  always_comb begin
    pc_d          = pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    wptr_d        = wptr_q;
    rptr_d        = rptr_q;
    if (redirect_i) begin
      pc_d   = redirect_pc_i & ALIGN_MASK;
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (issue) begin
        pc_d          = pc_q + PC_STEP;
        inflight_pc_d = pc_q;
      end
      if (push) wptr_d = wptr_q + PTR_ONE;
      if (pop)  rptr_d = rptr_q + PTR_ONE;
    end
  end

  // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      wptr_q        <= '0;
      rptr_q        <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
    end
  end

  // NOTE: storage is not reset; the pointers alone decide which entries are live.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= '{pc: inflight_pc_q, word: iram_rd_data_i};
  end

  assign iram_rd_en_o   = issue;
  assign iram_rd_addr_o = pc_q;
  assign inst_valid_o   = head_ok;
  assign inst_data_o    = head_ok ? head.word : NOP;
  assign inst_pc_o      = head_ok ? head.pc : '0;
  assign level_o        = level;

endmodule

// File: tb/tb_hxd_ifq.sv
// Directed testbench for hxd_ifq (DEPTH=4): stream, stall, redirect, wrap and zero-word scenarios.
// The IRAM model returns address+0x100, or 0 at zero_pc when zero_en is set.
module tb_hxd_ifq;

  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        iram_rd_en_o;
  logic [31:0] iram_rd_addr_o;
  logic [31:0] iram_rd_data_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        stall_i;
  logic        inst_valid_o;
  logic [31:0] inst_data_o;
  logic [31:0] inst_pc_o;
  logic [2:0]  level_o;
  logic        fault_o;

  logic [31:0] ram_q;
  logic [31:0] zero_pc;
  logic        zero_en;
  logic        en_prev;
  logic        mon_en;
  int          n_checks = 0;
  int          n_fail   = 0;

  hxd_ifq #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .iram_rd_en_o  (iram_rd_en_o),
    .iram_rd_addr_o(iram_rd_addr_o),
    .iram_rd_data_i(iram_rd_data_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .stall_i       (stall_i),
    .inst_valid_o  (inst_valid_o),
    .inst_data_o   (inst_data_o),
    .inst_pc_o     (inst_pc_o),
    .level_o       (level_o),
    .fault_o       (fault_o)
  );

  always #5 clk_i = ~clk_i;

  // Synchronous 1-cycle IRAM.
  always @(posedge clk_i)
    ram_q <= (zero_en && iram_rd_addr_o == zero_pc) ? 32'h0 : iram_rd_addr_o + 32'h100;
  assign iram_rd_data_i = ram_q;

  // Buffered entries plus the outstanding fetch may never exceed DEPTH (no push into a full FIFO).
  always @(posedge clk_i) en_prev <= iram_rd_en_o;
  always @(negedge clk_i) begin
    if (mon_en && !rst_i) begin
      n_checks++;
      if (int'(level_o) + int'(en_prev) > DEPTH) begin
        n_fail++; $display("FAIL credit_overflow: got level %0d + inflight %0d, want <= %0d", level_o, en_prev, DEPTH);
      end
    end
  end

  task automatic step(input logic st, input logic rd, input logic [31:0] rpc);
    @(posedge clk_i); #1;
    stall_i = st; redirect_i = rd; redirect_pc_i = rpc;
    #1;
  endtask

  task automatic do_reset(input logic st0);
    rst_i = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_i = 1'b0; stall_i = st0;
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    @(posedge clk_i); @(posedge clk_i); #2;
    n_checks++;
    if (iram_rd_en_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_en: got %b want 0", iram_rd_en_o);
    end
    n_checks++;
    if (iram_rd_addr_o !== 32'h0) begin
      n_fail++; $display("FAIL reset_addr: got %h want 00000000", iram_rd_addr_o);
    end
    n_checks++;
    if (inst_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b want 0", inst_valid_o);
    end
    n_checks++;
    if (inst_data_o !== 32'h13) begin
      n_fail++; $display("FAIL reset_data: got %h want 00000013", inst_data_o);
    end
    n_checks++;
    if (inst_pc_o !== 32'h0) begin
      n_fail++; $display("FAIL reset_pc: got %h want 00000000", inst_pc_o);
    end
    n_checks++;
    if (level_o !== 3'd0) begin
      n_fail++; $display("FAIL reset_level: got %0d want 0", level_o);
    end
    n_checks++;
    if (fault_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_fault: got %b want 0", fault_o);
    end
  endtask

  task automatic test_fetch_stream();
    logic [31:0] exp_pc;
    do_reset(1'b0);
    for (int c = 0; c < 10; c++) begin
      if (c > 0) step(1'b0, 1'b0, 32'h0);
      exp_pc = 32'(4 * (c - 2));
      n_checks++;
      if (iram_rd_en_o !== 1'b1 || iram_rd_addr_o !== 32'(4 * c)) begin
        n_fail++; $display("FAIL stream_fetch c%0d: got en %b addr %h want en 1 addr %h", c, iram_rd_en_o, iram_rd_addr_o, 32'(4 * c));
      end
      n_checks++;
      if (inst_valid_o !== (c >= 2) || level_o !== ((c >= 2) ? 3'd1 : 3'd0)) begin
        n_fail++; $display("FAIL stream_valid c%0d: got valid %b level %0d want valid %b level %0d", c, inst_valid_o, level_o, (c >= 2), (c >= 2) ? 1 : 0);
      end
      if (c >= 2) begin
        n_checks++;
        if (inst_pc_o !== exp_pc || inst_data_o !== exp_pc + 32'h100) begin
          n_fail++; $display("FAIL stream_head c%0d: got pc %h data %h want pc %h data %h", c, inst_pc_o, inst_data_o, exp_pc, exp_pc + 32'h100);
        end
      end
    end
  endtask

  task automatic test_stall();
    int          exp_lvl;
    logic [31:0] exp_pc;
    do_reset(1'b1);
    for (int c = 0; c < 10; c++) begin
      if (c > 0) step(1'b1, 1'b0, 32'h0);
      exp_lvl = (c <= 1) ? 0 : ((c - 1 > 4) ? 4 : c - 1);
      n_checks++;
      if (iram_rd_en_o !== (c < 4)) begin
        n_fail++; $display("FAIL stall_en c%0d: got %b want %b", c, iram_rd_en_o, (c < 4));
      end
      n_checks++;
      if (level_o !== 3'(exp_lvl)) begin
        n_fail++; $display("FAIL stall_level c%0d: got %0d want %0d", c, level_o, exp_lvl);
      end
      if (c >= 2) begin
        n_checks++;
        if (inst_valid_o !== 1'b1 || inst_pc_o !== 32'h0) begin
          n_fail++; $display("FAIL stall_head c%0d: got valid %b pc %h want valid 1 pc 00000000", c, inst_valid_o, inst_pc_o);
        end
      end
    end
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0, 32'h0);
      exp_pc = 32'(4 * k);
      n_checks++;
      if (inst_valid_o !== 1'b1 || inst_pc_o !== exp_pc || inst_data_o !== exp_pc + 32'h100) begin
        n_fail++; $display("FAIL release_head k%0d: got valid %b pc %h data %h want valid 1 pc %h data %h", k, inst_valid_o, inst_pc_o, inst_data_o, exp_pc, exp_pc + 32'h100);
      end
      n_checks++;
      if (level_o !== ((k == 0) ? 3'd4 : 3'd3)) begin
        n_fail++; $display("FAIL release_level k%0d: got %0d want %0d", k, level_o, (k == 0) ? 4 : 3);
      end
      n_checks++;
      if (iram_rd_en_o !== 1'b1 || iram_rd_addr_o !== 32'h10 + 32'(4 * k)) begin
        n_fail++; $display("FAIL release_fetch k%0d: got en %b addr %h want en 1 addr %h", k, iram_rd_en_o, iram_rd_addr_o, 32'h10 + 32'(4 * k));
      end
    end
  endtask

  task automatic test_redirect();
    do_reset(1'b1);
    for (int c = 1; c < 4; c++) step(1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h0000_0203);
    n_checks++;
    if (level_o !== 3'd3 || iram_rd_en_o !== 1'b0) begin
      n_fail++; $display("FAIL redir_cycle: got level %0d en %b want level 3 en 0", level_o, iram_rd_en_o);
    end
    step(1'b0, 1'b0, 32'h0);
    n_checks++;
    if (level_o !== 3'd0 || inst_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL redir_flush: got level %0d valid %b want level 0 valid 0", level_o, inst_valid_o);
    end
    n_checks++;
    if (iram_rd_en_o !== 1'b1 || iram_rd_addr_o !== 32'h200) begin
      n_fail++; $display("FAIL redir_target: got en %b addr %h want en 1 addr 00000200", iram_rd_en_o, iram_rd_addr_o);
    end
    step(1'b0, 1'b0, 32'h0);
    n_checks++;
    if (level_o !== 3'd0 || inst_valid_o !== 1'b0 || iram_rd_addr_o !== 32'h204) begin
      n_fail++; $display("FAIL redir_stale: got level %0d valid %b addr %h want level 0 valid 0 addr 00000204", level_o, inst_valid_o, iram_rd_addr_o);
    end
    step(1'b0, 1'b0, 32'h0);
    n_checks++;
    if (inst_valid_o !== 1'b1 || inst_pc_o !== 32'h200 || inst_data_o !== 32'h300) begin
      n_fail++; $display("FAIL redir_head: got valid %b pc %h data %h want valid 1 pc 00000200 data 00000300", inst_valid_o, inst_pc_o, inst_data_o);
    end
  endtask

  task automatic test_back_to_back_redirect();
    logic [31:0] targets [3];
    targets[0] = 32'h40; targets[1] = 32'h80; targets[2] = 32'hC0;
    do_reset(1'b0);
    for (int c = 1; c < 5; c++) step(1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, targets[k]);
      n_checks++;
      if (iram_rd_en_o !== 1'b0 || (k > 0 && level_o !== 3'd0)) begin
        n_fail++; $display("FAIL b2b_redir k%0d: got en %b level %0d want en 0 level 0", k, iram_rd_en_o, level_o);
      end
    end
    step(1'b0, 1'b0, 32'h0);
    n_checks++;
    if (iram_rd_en_o !== 1'b1 || iram_rd_addr_o !== 32'hC0 || level_o !== 3'd0) begin
      n_fail++; $display("FAIL b2b_target: got en %b addr %h level %0d want en 1 addr 000000c0 level 0", iram_rd_en_o, iram_rd_addr_o, level_o);
    end
    step(1'b0, 1'b0, 32'h0);
    n_checks++;
    if (inst_valid_o !== 1'b0 || level_o !== 3'd0) begin
      n_fail++; $display("FAIL b2b_gap: got valid %b level %0d want valid 0 level 0", inst_valid_o, level_o);
    end
    step(1'b0, 1'b0, 32'h0);
    n_checks++;
    if (inst_valid_o !== 1'b1 || inst_pc_o !== 32'hC0 || inst_data_o !== 32'h1C0) begin
      n_fail++; $display("FAIL b2b_head: got valid %b pc %h data %h want valid 1 pc 000000c0 data 000001c0", inst_valid_o, inst_pc_o, inst_data_o);
    end
  endtask

  task automatic test_pc_wrap();
    logic [31:0] exp_addr [3];
    logic [31:0] exp_pc   [3];
    exp_addr[0] = 32'hFFFF_FFF8; exp_addr[1] = 32'hFFFF_FFFC; exp_addr[2] = 32'h0000_0000;
    exp_pc[0]   = 32'hFFFF_FFF8; exp_pc[1]   = 32'hFFFF_FFFC; exp_pc[2]   = 32'h0000_0000;
    do_reset(1'b0);
    step(1'b0, 1'b1, 32'hFFFF_FFF8);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 32'h0);
      n_checks++;
      if (iram_rd_en_o !== 1'b1 || iram_rd_addr_o !== exp_addr[k]) begin
        n_fail++; $display("FAIL wrap_addr k%0d: got en %b addr %h want en 1 addr %h", k, iram_rd_en_o, iram_rd_addr_o, exp_addr[k]);
      end
    end
    for (int k = 0; k < 3; k++) begin
      if (k > 0) step(1'b0, 1'b0, 32'h0);
      n_checks++;
      if (inst_valid_o !== 1'b1 || inst_pc_o !== exp_pc[k] || inst_data_o !== exp_pc[k] + 32'h100) begin
        n_fail++; $display("FAIL wrap_head k%0d: got valid %b pc %h data %h want valid 1 pc %h data %h", k, inst_valid_o, inst_pc_o, inst_data_o, exp_pc[k], exp_pc[k] + 32'h100);
      end
    end
  endtask

  task automatic test_zero_word();
    logic [31:0] exp_pc;
    zero_pc = 32'h10;
    zero_en = 1'b1;
    do_reset(1'b0);
    for (int c = 1; c < 11; c++) begin
      step(1'b0, 1'b0, 32'h0);
      exp_pc = 32'(4 * (c - 2));
      if (c >= 2 && c <= 5) begin
        n_checks++;
        if (inst_valid_o !== 1'b1 || inst_pc_o !== exp_pc || fault_o !== 1'b0) begin
          n_fail++; $display("FAIL zero_pre c%0d: got valid %b pc %h fault %b want valid 1 pc %h fault 0", c, inst_valid_o, inst_pc_o, fault_o, exp_pc);
        end
      end
`ifdef HXD_IFQ_ZERO_FAULT_EN
      if (c == 6) begin
        n_checks++;
        if (inst_valid_o !== 1'b0 || fault_o !== 1'b0 || inst_data_o !== 32'h13) begin
          n_fail++; $display("FAIL zero_head: got valid %b fault %b data %h want valid 0 fault 0 data 00000013", inst_valid_o, fault_o, inst_data_o);
        end
      end
      if (c >= 7) begin
        n_checks++;
        if (fault_o !== 1'b1 || inst_valid_o !== 1'b0 || iram_rd_en_o !== 1'b0) begin
          n_fail++; $display("FAIL zero_fault c%0d: got fault %b valid %b en %b want fault 1 valid 0 en 0", c, fault_o, inst_valid_o, iram_rd_en_o);
        end
      end
`else
      if (c >= 6) begin
        n_checks++;
        if (inst_valid_o !== 1'b1 || inst_pc_o !== exp_pc || fault_o !== 1'b0 ||
            inst_data_o !== ((c == 6) ? 32'h0 : exp_pc + 32'h100)) begin
          n_fail++; $display("FAIL zero_deliver c%0d: got valid %b pc %h data %h fault %b want valid 1 pc %h data %h fault 0", c, inst_valid_o, inst_pc_o, inst_data_o, fault_o, exp_pc, (c == 6) ? 32'h0 : exp_pc + 32'h100);
        end
      end
`endif
    end
    // Mid-operation reset discards everything at the same edge.
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    #1;
    n_checks++;
    if (iram_rd_en_o !== 1'b0) begin
      n_fail++; $display("FAIL midreset_en: got %b want 0", iram_rd_en_o);
    end
    @(posedge clk_i); #2;
    n_checks++;
    if (level_o !== 3'd0 || inst_valid_o !== 1'b0 || fault_o !== 1'b0 || iram_rd_addr_o !== 32'h0) begin
      n_fail++; $display("FAIL midreset_state: got level %0d valid %b fault %b addr %h want 0 0 0 00000000", level_o, inst_valid_o, fault_o, iram_rd_addr_o);
    end
    zero_en = 1'b0;
    rst_i   = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    zero_en = 1'b0; zero_pc = 32'h0; mon_en = 1'b0;
    test_reset();
    mon_en = 1'b1;
    test_fetch_stream();
    test_stall();
    test_redirect();
    test_back_to_back_redirect();
    test_pc_wrap();
    test_zero_word();
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
